// File: rtl/gather_4_1_pkg.sv
// rtl/gather_4_1_pkg.sv - lane pointer type and helpers for the 4-to-1 gatherer
package gather_4_1_pkg;

    localparam int NUM_LANES = 4;
    localparam int PTR_W     = 2;

    typedef logic [PTR_W-1:0] lane_ptr_t;

    // Four lanes on a 2-bit pointer: natural overflow gives the 3 -> 0 wrap.
    function automatic lane_ptr_t next_lane(input lane_ptr_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/gather_lane_buf.sv
// rtl/gather_lane_buf.sv - one-deep valid/ready holding register for one gather lane
module gather_lane_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    input  logic             take_i,
    output logic             hold_valid_o,
    output logic [WIDTH-1:0] hold_data_o
);

    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;

    // Ready only reflects emptiness, so a lane being drained cannot refill on the same edge.
    assign in_ready_o   = ~hold_valid_q;
    assign hold_valid_o = hold_valid_q;
    assign hold_data_o  = hold_data_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (flush_i) begin
            hold_valid_d = 1'b0;
        end else if (take_i) begin
            hold_valid_d = 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: rtl/gather_4_1.sv
// rtl/gather_4_1.sv - ordered 4-to-1 gatherer with registered valid/ready output stage
module gather_4_1
    import gather_4_1_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid_0,
    input  logic              in_valid_1,
    input  logic              in_valid_2,
    input  logic              in_valid_3,
    input  logic [WIDTH-1:0]  in_data_0,
    input  logic [WIDTH-1:0]  in_data_1,
    input  logic [WIDTH-1:0]  in_data_2,
    input  logic [WIDTH-1:0]  in_data_3,
    output logic              in_ready_0,
    output logic              in_ready_1,
    output logic              in_ready_2,
    output logic              in_ready_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        out_sel,
    output logic              out_last,
    output logic [FCNT_W-1:0] frame_cnt
);

    logic [NUM_LANES-1:0] lane_valid_in, lane_ready, hold_valid, take;
    logic [WIDTH-1:0]     lane_data_in [NUM_LANES];
    logic [WIDTH-1:0]     hold_data    [NUM_LANES];

    lane_ptr_t         ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [1:0]        out_sel_q, out_sel_d;
    logic              out_last_q, out_last_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              stage_free, xfer;

    assign lane_valid_in   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
    assign lane_data_in[0] = in_data_0;
    assign lane_data_in[1] = in_data_1;
    assign lane_data_in[2] = in_data_2;
    assign lane_data_in[3] = in_data_3;
    assign {in_ready_3, in_ready_2, in_ready_1, in_ready_0} = lane_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        gather_lane_buf #(.WIDTH(WIDTH)) u_buf (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush_i      (flush),
            .in_valid_i   (lane_valid_in[i]),
            .in_data_i    (lane_data_in[i]),
            .in_ready_o   (lane_ready[i]),
            .take_i       (take[i]),
            .hold_valid_o (hold_valid[i]),
            .hold_data_o  (hold_data[i])
        );
    end

    // Only the lane under the pointer may drain; out-of-order lanes simply wait.
    assign stage_free = ~out_valid_q | out_ready;
    assign xfer       = hold_valid[ptr_q] & stage_free & ~flush;
    assign take       = xfer ? (4'b0001 << ptr_q) : 4'b0000;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        fcnt_d      = fcnt_q;
        if (flush) begin
            ptr_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (xfer) begin
                out_data_d  = hold_data[ptr_q];
                out_sel_d   = ptr_q;
                out_last_d  = (ptr_q == 2'd3);
                out_valid_d = 1'b1;
                ptr_d       = next_lane(ptr_q);
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (out_valid_q && out_ready && out_last_q) begin
                fcnt_d = fcnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_gather_4_1.sv
// tb/tb_gather_4_1.sv - directed scoreboard bench for gather_4_1
module tb_gather_4_1;

    localparam int WIDTH  = 16;
    localparam int FCNT_W = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [3:0]        in_valid;
    logic [WIDTH-1:0]  in_data [4];
    logic [3:0]        in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        out_sel;
    logic              out_last;
    logic [FCNT_W-1:0] frame_cnt;

    exp_t              sb[$];
    logic [FCNT_W-1:0] exp_fcnt;
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    gather_4_1 #(.WIDTH(WIDTH), .FCNT_W(FCNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid_0 (in_valid[0]),
        .in_valid_1 (in_valid[1]),
        .in_valid_2 (in_valid[2]),
        .in_valid_3 (in_valid[3]),
        .in_data_0  (in_data[0]),
        .in_data_1  (in_data[1]),
        .in_data_2  (in_data[2]),
        .in_data_3  (in_data[3]),
        .in_ready_0 (in_ready[0]),
        .in_ready_1 (in_ready[1]),
        .in_ready_2 (in_ready[2]),
        .in_ready_3 (in_ready[3]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_last   (out_last),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [1:0] s);
        sb.push_back('{data: d, sel: s, last: (s == 2'd3)});
    endtask

    task automatic drive(input int lane, input logic [WIDTH-1:0] d);
        in_valid[lane] = 1'b1;
        in_data[lane]  = d;
    endtask

    task automatic step_clear();
        tick();
        in_valid = 4'b0000;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, (n < 40) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Scoreboard: every handshake pops the next expected word; frame count tracked from expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_fcnt = '0;
        end else if (flush) begin
            sb.delete();
        end else begin
            n_cmp++;
            assert (frame_cnt === exp_fcnt) else begin
                n_err++;
                $error("FAIL frame_cnt: observed %0d expected %0d", frame_cnt, exp_fcnt);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL unexpected_out: observed %0h expected none", out_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_cmp++;
                    assert ({out_data, out_sel, out_last} === {e.data, e.sel, e.last}) else begin
                        n_err++;
                        $error("FAIL out_word: observed %0h/%0d/%0b expected %0h/%0d/%0b",
                               out_data, out_sel, out_last, e.data, e.sel, e.last);
                    end
                    if (e.last) exp_fcnt = exp_fcnt + 2'd1;
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i] = '0;
        repeat (3) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_in_ready", {28'd0, in_ready}, 32'hF);
        rst_n = 1'b1;
        tick();

        // All four lanes in the same cycle: full-rate ordered stream.
        push(16'h0011, 2'd0); push(16'h0022, 2'd1); push(16'h0033, 2'd2); push(16'h0044, 2'd3);
        drive(0, 16'h0011); drive(1, 16'h0022); drive(2, 16'h0033); drive(3, 16'h0044);
        step_clear();
        check("t2_capture_no_out", {31'd0, out_valid}, 32'd0);
        tick();
        check("t2_w0", {13'd0, out_data, out_sel, out_last}, {13'd0, 16'h0011, 2'd0, 1'b0});
        tick();
        check("t2_w1", {13'd0, out_data, out_sel, out_last}, {13'd0, 16'h0022, 2'd1, 1'b0});
        check("t2_lane0_refill_ready", {31'd0, in_ready[0]}, 32'd1);
        tick();
        check("t2_w2", {13'd0, out_data, out_sel, out_last}, {13'd0, 16'h0033, 2'd2, 1'b0});
        tick();
        check("t2_w3", {13'd0, out_data, out_sel, out_last}, {13'd0, 16'h0044, 2'd3, 1'b1});
        tick();
        check("t2_fcnt", {30'd0, frame_cnt}, 32'd1);
        check("t2_idle", {31'd0, out_valid}, 32'd0);

        // Out-of-order arrival: lane 2 waits for lanes 0 and 1.
        push(16'h0055, 2'd0); push(16'h0066, 2'd1); push(16'h00AA, 2'd2); push(16'h0077, 2'd3);
        drive(2, 16'h00AA);
        step_clear();
        check("t3_lane2_held", {31'd0, in_ready[2]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_no_out", {31'd0, out_valid}, 32'd0);
        end
        drive(0, 16'h0055);
        step_clear();
        check("t3_capture_no_out", {31'd0, out_valid}, 32'd0);
        tick();
        check("t3_w0", {14'd0, out_data, out_sel}, {14'd0, 16'h0055, 2'd0});
        check("t3_lane2_still_held", {31'd0, in_ready[2]}, 32'd0);
        drive(1, 16'h0066);
        step_clear();
        tick();
        check("t3_w1", {14'd0, out_data, out_sel}, {14'd0, 16'h0066, 2'd1});
        check("t3_lane2_wait", {31'd0, in_ready[2]}, 32'd0);
        tick();
        check("t3_w2", {14'd0, out_data, out_sel}, {14'd0, 16'h00AA, 2'd2});
        check("t3_lane2_freed", {31'd0, in_ready[2]}, 32'd1);
        drive(3, 16'h0077);
        step_clear();
        wait_idle("t3");
        check("t3_fcnt", {30'd0, frame_cnt}, 32'd2);

        // Backpressure: output stage and pointer frozen while out_ready is low.
        out_ready = 1'b0;
        push(16'h0011, 2'd0); push(16'h0022, 2'd1); push(16'h0033, 2'd2); push(16'h0044, 2'd3);
        drive(0, 16'h0011); drive(1, 16'h0022);
        step_clear();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t4_stall_word", {13'd0, out_valid, out_data, out_sel}, {13'd0, 1'b1, 16'h0011, 2'd0});
            check("t4_lane1_held", {31'd0, in_ready[1]}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t4_next_word", {13'd0, out_valid, out_data, out_sel}, {13'd0, 1'b1, 16'h0022, 2'd1});
        drive(2, 16'h0033); drive(3, 16'h0044);
        step_clear();
        wait_idle("t4");
        check("t4_fcnt", {30'd0, frame_cnt}, 32'd3);

        // Flush after two words: partial frame discarded, restart at lane 0.
        push(16'h00A0, 2'd0); push(16'h00A1, 2'd1);
        drive(0, 16'h00A0); drive(1, 16'h00A1); drive(2, 16'h00A2); drive(3, 16'h00A3);
        step_clear();
        tick();
        tick();
        check("t5_second_word", {14'd0, out_data, out_sel}, {14'd0, 16'h00A1, 2'd1});
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_flush_in_ready", {28'd0, in_ready}, 32'hF);
        check("t5_flush_fcnt", {30'd0, frame_cnt}, 32'd3);
        push(16'h00B0, 2'd0); push(16'h00B1, 2'd1); push(16'h00B2, 2'd2); push(16'h00B3, 2'd3);
        drive(0, 16'h00B0); drive(1, 16'h00B1); drive(2, 16'h00B2); drive(3, 16'h00B3);
        step_clear();
        tick();
        check("t5_restart_lane0", {14'd0, out_data, out_sel}, {14'd0, 16'h00B0, 2'd0});
        wait_idle("t5");
        check("t5_fcnt_wrap", {30'd0, frame_cnt}, 32'd0);

        // Four full frames on a 2-bit counter: 1,2,3,0.
        for (int f = 0; f < 4; f++) begin
            logic [31:0] want;
            for (int l = 0; l < 4; l++) begin
                logic [WIDTH-1:0] d;
                d = WIDTH'($urandom_range(0, 16'hFFFF));
                push(d, l[1:0]);
                drive(l, d);
            end
            step_clear();
            wait_idle("t6");
            want = (f + 1) % 4;
            check("t6_fcnt", {30'd0, frame_cnt}, want);
        end

        // Reset mid-traffic with a word stalled in the output stage.
        out_ready = 1'b0;
        drive(0, 16'h1234); drive(1, 16'h5678); drive(2, 16'h9ABC); drive(3, 16'hDEF0);
        step_clear();
        tick();
        rst_n = 1'b0;
        #2;
        check("t1_rst_outputs", {12'd0, out_valid, out_data, out_sel, out_last},
              {12'd0, 1'b0, 16'h0000, 2'd0, 1'b0});
        check("t1_rst_fcnt", {30'd0, frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t1_rst_in_ready", {28'd0, in_ready}, 32'hF);
        check("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
